// File: rtl/peripheral_bus_bridge.sv
// Valid/ready host port to peripheral register file and 256x32 memory bridge.
// One transaction in flight; decodes COUNT/CONFIG/STATUS and the memory window.
module peripheral_bus_bridge #(
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [11:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        count_we,
  output logic [31:0] count_in,
  input  logic [31:0] count_out,
  output logic        config_we,
  output logic        en_in,
  output logic        dir_in,
  output logic        ire_in,
  input  logic        en_out,
  input  logic        dir_out,
  input  logic        ire_out,
  input  logic        lt_1k_out,
  output logic        mem_write_en,
  output logic [7:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] MWAIT = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [2:0] TGT_COUNT  = 3'd0;
  localparam logic [2:0] TGT_CONFIG = 3'd1;
  localparam logic [2:0] TGT_STATUS = 3'd2;
  localparam logic [2:0] TGT_MEM    = 3'd3;
  localparam logic [2:0] TGT_ERR    = 3'd4;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_RD_LATENCY - 1);

  logic [1:0]  state;
  logic        wr_q;
  logic [2:0]  tgt_q;
  logic [2:0]  wait_cnt;
  logic [2:0]  req_tgt;
  logic [31:0] reg_rdata;

  // Misaligned, unmapped and STATUS writes all collapse to TGT_ERR.
  function automatic logic [2:0] decode_target(input logic [11:0] addr,
                                               input logic        wr);
    logic [2:0] tgt;
    tgt = TGT_ERR;
    if (addr[1:0] == 2'b00) begin
      if (addr[11:10] == 2'b01) begin
        tgt = TGT_MEM;
      end else begin
        case (addr)
          12'h000: tgt = TGT_COUNT;
          12'h004: tgt = TGT_CONFIG;
          12'h008: tgt = wr ? TGT_ERR : TGT_STATUS;
          default: tgt = TGT_ERR;
        endcase
      end
    end
    return tgt;
  endfunction

  assign req_tgt   = decode_target(req_addr, req_write);
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    reg_rdata = 32'd0;
    case (tgt_q)
      TGT_COUNT:  reg_rdata = count_out;
      TGT_CONFIG: reg_rdata = {29'd0, ire_out, dir_out, en_out};
      TGT_STATUS: reg_rdata = {31'd0, lt_1k_out};
      default:    reg_rdata = 32'd0;
    endcase
  end

  // Strobes are registered at acceptance so they are high for exactly the EXEC cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      wr_q         <= 1'b0;
      tgt_q        <= TGT_ERR;
      wait_cnt     <= 3'd0;
      rsp_rdata    <= 32'd0;
      rsp_err      <= 1'b0;
      count_we     <= 1'b0;
      count_in     <= 32'd0;
      config_we    <= 1'b0;
      en_in        <= 1'b0;
      dir_in       <= 1'b0;
      ire_in       <= 1'b0;
      mem_write_en <= 1'b0;
      mem_address  <= 8'd0;
      mem_data_in  <= 32'd0;
    end else begin
      count_we     <= 1'b0;
      config_we    <= 1'b0;
      mem_write_en <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q         <= req_write;
            tgt_q        <= req_tgt;
            count_in     <= req_wdata;
            en_in        <= req_wdata[0];
            dir_in       <= req_wdata[1];
            ire_in       <= req_wdata[2];
            mem_data_in  <= req_wdata;
            mem_address  <= req_addr[9:2];
            count_we     <= req_write && (req_tgt == TGT_COUNT);
            config_we    <= req_write && (req_tgt == TGT_CONFIG);
            mem_write_en <= req_write && (req_tgt == TGT_MEM);
            state        <= EXEC;
          end
        end
        EXEC: begin
          if (!wr_q && (tgt_q == TGT_MEM)) begin
            wait_cnt <= 3'd0;
            state    <= MWAIT;
          end else begin
            rsp_err   <= (tgt_q == TGT_ERR);
            rsp_rdata <= wr_q ? 32'd0 : reg_rdata;
            state     <= RESP;
          end
        end
        MWAIT: begin
          if (wait_cnt == WAIT_LAST) begin
            rsp_rdata <= mem_data_out;
            rsp_err   <= 1'b0;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
